// File: rtl/oversampler_vote_if.sv
// Bundle of the oversampler's data-path signals between the RX bit counter/FSM
// side (master) and the majority-vote sampler (slave).
interface oversampler_vote_if #(
    parameter int PRESCALE_W = 6
);
    logic                  Enable;
    logic [PRESCALE_W-1:0] Prescale;
    logic [PRESCALE_W-1:0] EdgeCounter;
    logic                  SData;
    logic                  SampledBit;
    logic                  SampledValid;
    logic                  NoiseFlag;
    logic                  ConfigError;

    modport master (
        output Enable, Prescale, EdgeCounter, SData,
        input  SampledBit, SampledValid, NoiseFlag, ConfigError
    );

    modport slave (
        input  Enable, Prescale, EdgeCounter, SData,
        output SampledBit, SampledValid, NoiseFlag, ConfigError
    );
endinterface

// File: rtl/oversampler_vote.sv
// Majority-vote UART RX oversampler: synchronises the line, collects NUM_SAMPLES
// samples centred in each bit period and emits the voted bit with a noise flag.
module oversampler_vote #(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    oversampler_vote_if.slave   bus
);
    localparam int H  = (NUM_SAMPLES - 1) / 2;
    localparam int CW = $clog2(NUM_SAMPLES + 1);
    localparam int GW = PRESCALE_W + 1;
    localparam logic [GW-1:0] H_G   = GW'(H);
    localparam logic [CW-1:0] N_C   = CW'(NUM_SAMPLES);
    localparam logic [CW-1:0] H_C   = CW'(H);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    function automatic logic [CW-1:0] popcount(input logic [NUM_SAMPLES-1:0] vec);
        logic [CW-1:0] acc;
        acc = {CW{1'b0}};
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            acc = acc + CW'(vec[i]);
        end
        return acc;
    endfunction

    logic sd_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sd_s = bus.SData;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_r;

            // Input synchroniser; idles high like the serial line
            always_ff @(posedge CLK) begin
                if (RST) begin
                    sync_r <= {SYNC_STAGES{1'b1}};
                end else begin
                    sync_r[0] <= bus.SData;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_r[i] <= sync_r[i-1];
                    end
                end
            end

            assign sd_s = sync_r[SYNC_STAGES-1];
        end
    endgenerate

    logic [GW-1:0]          pres_s;
    logic [GW-1:0]          ec_s;
    logic [GW-1:0]          c_s;
    logic [GW-1:0]          l_s;
    logic [GW-1:0]          u_s;
    logic [GW-1:0]          v_s;
    logic                   cfg_err_s;
    logic                   in_win_s;
    logic                   at_vote_s;
    logic [CW-1:0]          ones_s;

    logic [NUM_SAMPLES-1:0] samp_r;
    logic [CW-1:0]          cnt_r;
    logic                   bit_r;
    logic                   valid_r;
    logic                   noise_r;

    // Window geometry from the live Prescale; one extra bit keeps bounds from wrapping
    always_comb begin
        pres_s    = {1'b0, bus.Prescale};
        ec_s      = {1'b0, bus.EdgeCounter};
        c_s       = pres_s >> 1;
        l_s       = c_s - H_G;
        u_s       = c_s + H_G;
        v_s       = u_s + GW'(1);
        // V > Prescale-1 written as V+1 > Prescale so Prescale=0 cannot underflow
        cfg_err_s = (c_s < (H_G + GW'(1))) || ((v_s + GW'(1)) > pres_s);
        in_win_s  = bus.Enable && !cfg_err_s && (ec_s >= l_s) && (ec_s <= u_s);
        at_vote_s = bus.Enable && !cfg_err_s && (ec_s == v_s);
        ones_s    = popcount(samp_r);
    end

    // Sample collection, vote and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            samp_r  <= {NUM_SAMPLES{1'b0}};
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 1'b0;
            valid_r <= 1'b0;
            noise_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (!bus.Enable || cfg_err_s) begin
                cnt_r <= {CW{1'b0}};
            end else if (in_win_s) begin
                samp_r <= {samp_r[NUM_SAMPLES-2:0], sd_s};
                if (ec_s == l_s) begin
                    cnt_r <= ONE_C;
                end else if (cnt_r == N_C) begin
                    cnt_r <= cnt_r;
                end else begin
                    cnt_r <= cnt_r + ONE_C;
                end
            end else if (at_vote_s) begin
                // A window that did not start at L is discarded without a strobe
                cnt_r <= {CW{1'b0}};
                if (cnt_r == N_C) begin
                    bit_r   <= (ones_s > H_C);
                    noise_r <= (ones_s != {CW{1'b0}}) && (ones_s != N_C);
                    valid_r <= 1'b1;
                end else begin
                    valid_r <= 1'b0;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.SampledBit   = bit_r;
    assign bus.SampledValid = valid_r;
    assign bus.NoiseFlag    = noise_r;
    assign bus.ConfigError  = cfg_err_s;

endmodule
